// File: rtl/vx_dispatch_lane_buf.sv
// ============================================================================
//  Module   : vx_dispatch_lane_buf
//  Purpose  : 2-entry elastic (skid) FIFO for one dispatcher output lane.
//             full/empty come straight from registered occupancy, so the
//             producer-side ready never depends on the consumer's ready.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vx_dispatch_lane_buf #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic [DATAW-1:0] head_data,
  output logic             empty,
  output logic             full
);

  logic [DATAW-1:0] mem_q [2];
  logic [DATAW-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  // Next-state: write at wr_ptr, read at rd_ptr, occupancy tracks push minus pop.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards any buffered items.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);

endmodule

`default_nettype wire

// File: rtl/vx_cyclic_dispatcher.sv
// ============================================================================
//  Module   : vx_cyclic_dispatcher
//  Purpose  : Round-robin fan-out of one valid/ready stream to NUM_OUTPUTS
//             lanes, with optional strict ordering and per-lane buffering.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vx_cyclic_dispatcher #(
  parameter int NUM_OUTPUTS     = 4,
  parameter int DATAW           = 32,
  parameter bit STRICT          = 1'b1,
  parameter bit OUT_BUF         = 1'b1,
  parameter int LOG_NUM_OUTPUTS = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [DATAW-1:0]             data_in,
  output logic                         ready_in,
  output logic [NUM_OUTPUTS-1:0]       valid_out,
  output logic [NUM_OUTPUTS*DATAW-1:0] data_out,
  input  logic [NUM_OUTPUTS-1:0]       ready_out,
  output logic [LOG_NUM_OUTPUTS-1:0]   next_index
);

  localparam logic [LOG_NUM_OUTPUTS-1:0] LAST_IDX = LOG_NUM_OUTPUTS'(NUM_OUTPUTS - 1);

  // (base + offs) mod NUM_OUTPUTS; both operands are already below NUM_OUTPUTS.
  function automatic logic [LOG_NUM_OUTPUTS-1:0] add_mod(
    input logic [LOG_NUM_OUTPUTS-1:0] base,
    input int unsigned                offs
  );
    int unsigned sum;
    sum = 32'(base) + offs;
    if (sum >= 32'(NUM_OUTPUTS)) begin
      sum = sum - 32'(NUM_OUTPUTS);
    end
    return sum[LOG_NUM_OUTPUTS-1:0];
  endfunction

  // Pointer increment that wraps at the last lane, also for non-power-of-2 counts.
  function automatic logic [LOG_NUM_OUTPUTS-1:0] wrap_inc(
    input logic [LOG_NUM_OUTPUTS-1:0] p
  );
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  logic [LOG_NUM_OUTPUTS-1:0] ptr_q, ptr_d;
  logic [LOG_NUM_OUTPUTS-1:0] target;
  logic [LOG_NUM_OUTPUTS-1:0] first_off;
  logic [NUM_OUTPUTS-1:0]     lane_rdy;
  logic [NUM_OUTPUTS-1:0]     rot_rdy;
  logic                       found;
  logic                       fire;

  // Target pick: rotate readiness by ptr, take the lowest ready offset, add ptr back.
  always_comb begin
    rot_rdy   = '0;
    first_off = '0;
    found     = 1'b0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      rot_rdy[j] = lane_rdy[add_mod(ptr_q, 32'(j))];
    end
    for (int j = NUM_OUTPUTS - 1; j >= 0; j--) begin
      if (rot_rdy[j]) begin
        first_off = LOG_NUM_OUTPUTS'(j);
        found     = 1'b1;
      end
    end
    if (STRICT || !found) begin
      target = ptr_q;
    end else begin
      target = add_mod(ptr_q, 32'(first_off));
    end
  end

  assign ready_in   = lane_rdy[target];
  assign fire       = valid_in && ready_in;
  assign next_index = ptr_q;

  // Pointer advances past the lane just served and holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = wrap_inc(target);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  generate
    if (OUT_BUF) begin : g_buf
      for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
        logic lane_full;
        logic lane_empty;

        vx_dispatch_lane_buf #(
          .DATAW (DATAW)
        ) u_lane_buf (
          .clk       (clk),
          .reset     (reset),
          .push      (fire && (target == LOG_NUM_OUTPUTS'(i))),
          .push_data (data_in),
          .pop       (!lane_empty && ready_out[i]),
          .head_data (data_out[i*DATAW +: DATAW]),
          .empty     (lane_empty),
          .full      (lane_full)
        );

        assign lane_rdy[i]  = ~lane_full;
        assign valid_out[i] = ~lane_empty;
      end
    end else begin : g_comb
      assign lane_rdy = ready_out;
      for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
        assign valid_out[i]                = valid_in && (target == LOG_NUM_OUTPUTS'(i)) && lane_rdy[i];
        assign data_out[i*DATAW +: DATAW]  = data_in;
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vx_cyclic_dispatcher.sv
// ============================================================================
//  Module   : tb_vx_cyclic_dispatcher
//  Purpose  : Directed bench for vx_cyclic_dispatcher across several configs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vx_cyclic_dispatcher;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---- s4: 4 lanes, strict, combinational ----
  logic        s4_valid = 0;  logic [7:0]  s4_data = 0;  logic        s4_rin;
  logic [3:0]  s4_vo;         logic [31:0] s4_do;        logic [3:0]  s4_ro = '1;
  logic [1:0]  s4_idx;
  vx_cyclic_dispatcher #(.NUM_OUTPUTS(4), .DATAW(8), .STRICT(1), .OUT_BUF(0)) u_s4 (
    .clk(clk), .reset(reset), .valid_in(s4_valid), .data_in(s4_data), .ready_in(s4_rin),
    .valid_out(s4_vo), .data_out(s4_do), .ready_out(s4_ro), .next_index(s4_idx));

  // ---- s3: 3 lanes, strict, combinational ----
  logic        s3_valid = 0;  logic [7:0]  s3_data = 0;  logic        s3_rin;
  logic [2:0]  s3_vo;         logic [23:0] s3_do;        logic [2:0]  s3_ro = '1;
  logic [1:0]  s3_idx;
  vx_cyclic_dispatcher #(.NUM_OUTPUTS(3), .DATAW(8), .STRICT(1), .OUT_BUF(0)) u_s3 (
    .clk(clk), .reset(reset), .valid_in(s3_valid), .data_in(s3_data), .ready_in(s3_rin),
    .valid_out(s3_vo), .data_out(s3_do), .ready_out(s3_ro), .next_index(s3_idx));

  // ---- k4: 4 lanes, skip mode, combinational ----
  logic        k4_valid = 0;  logic [7:0]  k4_data = 0;  logic        k4_rin;
  logic [3:0]  k4_vo;         logic [31:0] k4_do;        logic [3:0]  k4_ro = '1;
  logic [1:0]  k4_idx;
  vx_cyclic_dispatcher #(.NUM_OUTPUTS(4), .DATAW(8), .STRICT(0), .OUT_BUF(0)) u_k4 (
    .clk(clk), .reset(reset), .valid_in(k4_valid), .data_in(k4_data), .ready_in(k4_rin),
    .valid_out(k4_vo), .data_out(k4_do), .ready_out(k4_ro), .next_index(k4_idx));

  // ---- b2: 2 lanes, strict, buffered ----
  logic        b2_valid = 0;  logic [7:0]  b2_data = 0;  logic        b2_rin;
  logic [1:0]  b2_vo;         logic [15:0] b2_do;        logic [1:0]  b2_ro = '0;
  logic [0:0]  b2_idx;
  vx_cyclic_dispatcher #(.NUM_OUTPUTS(2), .DATAW(8), .STRICT(1), .OUT_BUF(1)) u_b2 (
    .clk(clk), .reset(reset), .valid_in(b2_valid), .data_in(b2_data), .ready_in(b2_rin),
    .valid_out(b2_vo), .data_out(b2_do), .ready_out(b2_ro), .next_index(b2_idx));

  // ---- b4: 4 lanes, strict, buffered ----
  logic        b4_valid = 0;  logic [7:0]  b4_data = 0;  logic        b4_rin;
  logic [3:0]  b4_vo;         logic [31:0] b4_do;        logic [3:0]  b4_ro = '0;
  logic [1:0]  b4_idx;
  vx_cyclic_dispatcher #(.NUM_OUTPUTS(4), .DATAW(8), .STRICT(1), .OUT_BUF(1)) u_b4 (
    .clk(clk), .reset(reset), .valid_in(b4_valid), .data_in(b4_data), .ready_in(b4_rin),
    .valid_out(b4_vo), .data_out(b4_do), .ready_out(b4_ro), .next_index(b4_idx));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // sel: 0 = s4, 1 = s3, 2 = k4
  typedef struct {
    int         sel;
    logic       valid;
    logic [7:0] data;
    logic [3:0] rdy;
    logic       exp_rin;
    logic [3:0] exp_vo;
    logic [1:0] exp_idx;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input int sel, input logic v, input logic [7:0] d,
                              input logic [3:0] r, input logic eri,
                              input logic [3:0] evo, input logic [1:0] eidx);
    vec_t t;
    t.sel = sel; t.valid = v; t.data = d; t.rdy = r;
    t.exp_rin = eri; t.exp_vo = evo; t.exp_idx = eidx;
    return t;
  endfunction

  initial begin
    logic [3:0]  vo;
    logic [31:0] dout;
    logic        rin;
    logic [1:0]  idx;

    // reset state, strict rotation
    vecs[0]  = mk(0, 0, 8'h00, 4'b1111, 1, 4'b0000, 0);
    vecs[1]  = mk(0, 0, 8'h00, 4'b0000, 0, 4'b0000, 0);
    vecs[2]  = mk(0, 1, 8'h10, 4'b1111, 1, 4'b0001, 0);
    vecs[3]  = mk(0, 1, 8'h11, 4'b1111, 1, 4'b0010, 1);
    vecs[4]  = mk(0, 1, 8'h12, 4'b1111, 1, 4'b0100, 2);
    vecs[5]  = mk(0, 1, 8'h13, 4'b1111, 1, 4'b1000, 3);
    vecs[6]  = mk(0, 1, 8'h14, 4'b1111, 1, 4'b0001, 0);
    vecs[7]  = mk(0, 1, 8'h15, 4'b1111, 1, 4'b0010, 1);
    vecs[8]  = mk(0, 1, 8'h16, 4'b1111, 1, 4'b0100, 2);
    vecs[9]  = mk(0, 1, 8'h17, 4'b1111, 1, 4'b1000, 3);
    // strict stall at ptr=1
    vecs[10] = mk(0, 1, 8'h20, 4'b1111, 1, 4'b0001, 0);
    vecs[11] = mk(0, 1, 8'h21, 4'b1101, 0, 4'b0000, 1);
    vecs[12] = mk(0, 1, 8'h21, 4'b1101, 0, 4'b0000, 1);
    vecs[13] = mk(0, 1, 8'h21, 4'b1111, 1, 4'b0010, 1);
    vecs[14] = mk(0, 0, 8'h00, 4'b1111, 1, 4'b0000, 2);
    // non-power-of-2 wrap
    vecs[15] = mk(1, 1, 8'h60, 4'b0111, 1, 4'b0001, 0);
    vecs[16] = mk(1, 1, 8'h61, 4'b0111, 1, 4'b0010, 1);
    vecs[17] = mk(1, 1, 8'h62, 4'b0111, 1, 4'b0100, 2);
    vecs[18] = mk(1, 1, 8'h63, 4'b0111, 1, 4'b0001, 0);
    vecs[19] = mk(1, 1, 8'h64, 4'b0111, 1, 4'b0010, 1);
    vecs[20] = mk(1, 1, 8'h65, 4'b0111, 1, 4'b0100, 2);
    vecs[21] = mk(1, 1, 8'h66, 4'b0111, 1, 4'b0001, 0);
    vecs[22] = mk(1, 0, 8'h00, 4'b0111, 1, 4'b0000, 1);
    // skip mode
    vecs[23] = mk(2, 1, 8'h30, 4'b1111, 1, 4'b0001, 0);
    vecs[24] = mk(2, 1, 8'h31, 4'b1001, 1, 4'b1000, 1);
    vecs[25] = mk(2, 1, 8'h32, 4'b1001, 1, 4'b0001, 0);
    vecs[26] = mk(2, 0, 8'h00, 4'b1001, 1, 4'b0000, 1);
    vecs[27] = mk(2, 0, 8'h00, 4'b1001, 1, 4'b0000, 1);
    vecs[28] = mk(2, 1, 8'h33, 4'b0000, 0, 4'b0000, 1);
    vecs[29] = mk(2, 1, 8'h33, 4'b0100, 1, 4'b0100, 1);
    vecs[30] = mk(2, 0, 8'h00, 4'b1111, 1, 4'b0000, 3);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      s4_valid = 0; s3_valid = 0; k4_valid = 0;
      case (vecs[n].sel)
        0: begin s4_valid = vecs[n].valid; s4_data = vecs[n].data; s4_ro = vecs[n].rdy; end
        1: begin s3_valid = vecs[n].valid; s3_data = vecs[n].data; s3_ro = vecs[n].rdy[2:0]; end
        default: begin k4_valid = vecs[n].valid; k4_data = vecs[n].data; k4_ro = vecs[n].rdy; end
      endcase
      #2;
      case (vecs[n].sel)
        0:       begin rin = s4_rin; vo = s4_vo;         idx = s4_idx; dout = s4_do; end
        1:       begin rin = s3_rin; vo = {1'b0, s3_vo}; idx = s3_idx; dout = {8'h00, s3_do}; end
        default: begin rin = k4_rin; vo = k4_vo;         idx = k4_idx; dout = k4_do; end
      endcase
      chk($sformatf("vec%0d ready_in", n),   32'(rin), 32'(vecs[n].exp_rin));
      chk($sformatf("vec%0d valid_out", n),  32'(vo),  32'(vecs[n].exp_vo));
      chk($sformatf("vec%0d next_index", n), 32'(idx), 32'(vecs[n].exp_idx));
      for (int l = 0; l < 4; l++) begin
        if (vecs[n].exp_vo[l]) begin
          chk($sformatf("vec%0d data_lane%0d", n, l), 32'(dout[l*8 +: 8]), 32'(vecs[n].data));
        end
      end
    end
    @(negedge clk);
    s4_valid = 0; s3_valid = 0; k4_valid = 0;

    // ---- buffered backpressure on b2 ----
    #2;
    chk("b2 reset ready_in", 32'(b2_rin), 32'h1);
    chk("b2 reset valid_out", 32'(b2_vo), 32'h0);
    b2_ro = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b2_valid = 1'b1;
      b2_data  = 8'h40 + 8'(k);
      #2;
      chk($sformatf("b2 offer%0d ready_in", k), 32'(b2_rin), (k < 4) ? 32'h1 : 32'h0);
    end
    chk("b2 full valid_out", 32'(b2_vo), 32'h3);
    chk("b2 full next_index", 32'(b2_idx), 32'h0);
    chk("b2 lane0 head", 32'(b2_do[7:0]), 32'h40);
    chk("b2 lane1 head", 32'(b2_do[15:8]), 32'h41);
    // ready_in must not follow ready_out combinationally
    b2_ro = 2'b01;
    #1;
    chk("b2 ready_in vs ro=01", 32'(b2_rin), 32'h0);
    b2_ro = 2'b00;
    #1;
    chk("b2 ready_in vs ro=00", 32'(b2_rin), 32'h0);
    b2_ro = 2'b01;
    @(negedge clk);   // lane 0 popped 0x40
    #2;
    chk("b2 drain ready_in", 32'(b2_rin), 32'h1);
    chk("b2 lane0 second head", 32'(b2_do[7:0]), 32'h42);
    chk("b2 lane0 valid", 32'(b2_vo[0]), 32'h1);
    @(negedge clk);   // 0x42 popped, 0x44 pushed to lane 0 in the same edge
    b2_valid = 1'b0;
    #2;
    chk("b2 lane0 fifth head", 32'(b2_do[7:0]), 32'h44);
    chk("b2 after fifth next_index", 32'(b2_idx), 32'h1);
    chk("b2 after fifth valid_out", 32'(b2_vo), 32'h3);
    @(negedge clk);   // 0x44 popped
    #2;
    chk("b2 drained valid_out", 32'(b2_vo), 32'h2);
    chk("b2 lane1 untouched", 32'(b2_do[15:8]), 32'h41);

    // ---- reset mid-stream on b4 ----
    b4_ro = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b4_valid = 1'b1;
      b4_data  = 8'h50 + 8'(k);
    end
    @(negedge clk);
    b4_valid = 1'b0;
    #2;
    chk("b4 pre-reset valid_out", 32'(b4_vo), 32'h3);
    chk("b4 pre-reset next_index", 32'(b4_idx), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("b4 post-reset valid_out", 32'(b4_vo), 32'h0);
    chk("b4 post-reset next_index", 32'(b4_idx), 32'h0);
    chk("b4 post-reset ready_in", 32'(b4_rin), 32'h1);
    @(negedge clk);
    b4_valid = 1'b1;
    b4_data  = 8'h52;
    @(negedge clk);
    b4_valid = 1'b0;
    #2;
    chk("b4 next item lane", 32'(b4_vo), 32'h1);
    chk("b4 next item data", 32'(b4_do[7:0]), 32'h52);
    chk("b4 next item next_index", 32'(b4_idx), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_cyclic_dispatcher.md
# vx_cyclic_dispatcher

Distributes one valid/ready input stream across `NUM_OUTPUTS` output streams in cyclic (round-robin) order. It is the fan-out counterpart of the cyclic arbiter: the arbiter merges N requesters into one, and this block splits one producer across N consumers, such as per-bank or per-lane work queues. An optional per-lane output buffer cuts the combinational `ready` path from consumers back to the producer.

## Interface

Parameters:
- `NUM_OUTPUTS`, default 4: number of output lanes; must be ≥ 1; need not be a power of 2.
- `DATAW`, default 32: payload width in bits.
- `STRICT`, default 1:
  - 1 = wait on the current target lane.
  - 0 = skip to the next ready lane in circular order.
- `OUT_BUF`, default 1:
  - 0 = combinational outputs.
  - 1 = per-lane 2-entry elastic buffer.
- `LOG_NUM_OUTPUTS`, default `LOG2UP(NUM_OUTPUTS)`: pointer width.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `valid_in`  in  1: input item valid.
- `data_in`  in  `DATAW`: input payload.
- `ready_in`  out  1: block accepts the item this cycle.
- `valid_out`  out  `NUM_OUTPUTS`: per-lane valid.
- `data_out`  out  `NUM_OUTPUTS*DATAW`: lane i occupies bits `[i*DATAW +: DATAW]`.
- `ready_out`  in  `NUM_OUTPUTS`: per-lane consumer ready.
- `next_index`  out  `LOG_NUM_OUTPUTS`: current value of the round-robin pointer.

## Operation

- **Lane readiness.** `lane_rdy[i]` is `ready_out[i]` when `OUT_BUF`=0. It is "lane i buffer not full" when `OUT_BUF`=1.
- **Target selection.**
  - `STRICT`=1: target = `ptr`.
  - `STRICT`=0: target = first i with `lane_rdy[i]`, searched circularly starting at `ptr`. If no lane is ready, target = `ptr`.
- **Accept.** `ready_in` = `lane_rdy[target]`. A transfer (fire) occurs when `valid_in && ready_in`.
- **Pointer update.**
  - On fire: `ptr` ← target+1, wrapping from `NUM_OUTPUTS`-1 to 0 for any `NUM_OUTPUTS`, including non-power-of-2.
  - With no fire: `ptr` holds. Unlike the arbiter, the pointer never free-runs.
- **Output, `OUT_BUF`=0.**
  - `valid_out[i]` = `valid_in && (i == target) && lane_rdy[i]`.
  - `data_out` carries `data_in` on every lane; only the target lane's valid is asserted.
- **Output, `OUT_BUF`=1.**
  - The fired item is written into lane target's buffer.
  - Each lane buffer is a 2-entry FIFO (a skid pair).
  - `valid_out[i]` = buffer non-empty. `data_out` lane i = head entry.
  - The head pops when `valid_out[i] && ready_out[i]`.
  - A push and a pop on the same lane in the same cycle are both legal: occupancy is unchanged and order is preserved.
  - "Not full" is derived from registered occupancy only. There is no combinational path from `ready_out` to `ready_in`.
- **Single-lane case.** `NUM_OUTPUTS`=1 degenerates to a pass-through (`OUT_BUF`=0) or a single buffer (`OUT_BUF`=1). `ptr` is constant 0 and `next_index` = 0.
- **Ordering guarantee.** Items delivered on a given lane appear in input order. Globally, items i and i+`NUM_OUTPUTS` map to the same lane when `STRICT`=1 and no stall reorders lanes.

## Timing

- **Reset values.**
  - `ptr` = 0, so `next_index` = 0.
  - All lane buffers empty; `valid_out` = 0.
  - `ready_in` = `lane_rdy[0]`: 1 when `OUT_BUF`=1, and equal to `ready_out[0]` when `OUT_BUF`=0.
- **Latency.** `OUT_BUF`=0 has 0 cycles from input to `valid_out`. `OUT_BUF`=1 has 1 cycle.
- **Throughput.** One item per cycle when the target lane is ready.
  - With `OUT_BUF`=1 and all consumers stalled, each lane absorbs 2 items before `ready_in` drops for that lane.
- **Reset asserted mid-operation.** Buffered items are discarded, `ptr` returns to 0, and `valid_out` is 0 on the cycle after reset is sampled.
- **Handshake rules.**
  - The producer must hold `valid_in`/`data_in` stable until fire.
  - The block never drops or duplicates an item.
  - When `STRICT`=0 and `valid_in` is low, `ptr` does not move.

## Structure

- No shared package is needed. The pointer-wrap helper is a local function.
- One sub-module: `vx_dispatch_lane_buf`.
  - Contents: 2-entry FIFO with push/pop, registered `full`/`empty`, and `DATAW` payload.
  - Instantiated `NUM_OUTPUTS` times under a generate loop when `OUT_BUF`=1.
- The circular first-ready search (`STRICT`=0) is done by rotating `lane_rdy` by `ptr`, priority-encoding, and adding `ptr` back modulo `NUM_OUTPUTS`.

## Test plan

- **Strict rotation.** Config: `NUM_OUTPUTS`=4, `STRICT`=1, `OUT_BUF`=0, all `ready_out`=1, inputs 0x10–0x17 back to back.
  - Required: lanes 0,1,2,3,0,1,2,3 receive 0x10..0x17 in order.
  - Required: `next_index` sequence 0,1,2,3,0,…
- **Non-power-of-2 wrap.** Config: `NUM_OUTPUTS`=3, `STRICT`=1, 7 items.
  - Required: lane sequence 0,1,2,0,1,2,0.
  - Required: `ptr` never equals 3.
- **Strict stall.** Config: `STRICT`=1, `ready_out`=4'b1101, `ptr`=1.
  - Required: `ready_in`=0 and `ptr` holds at 1.
  - Then raise `ready_out[1]`: fire to lane 1 and `ptr` becomes 2.
- **Skip mode.** Config: `STRICT`=0, `OUT_BUF`=0, `ptr`=1, `ready_out`=4'b1001.
  - Required: item goes to lane 3 and `ptr` becomes 0.
  - Next item with the same `ready_out` goes to lane 0 and `ptr` becomes 1.
- **Buffered backpressure.** Config: `OUT_BUF`=1, `STRICT`=1, `NUM_OUTPUTS`=2, all `ready_out`=0, 5 items offered.
  - Required: 4 items accepted (2 per lane); `ready_in` drops on the 5th.
  - Release `ready_out[0]`: lane 0 drains the 1st then 3rd items in order, and the 5th is accepted.
  - Required: no combinational dependence of `ready_in` on `ready_out` (toggle `ready_out` mid-cycle and check `ready_in` is unaffected).
- **Reset mid-stream.** Config: `OUT_BUF`=1, lanes 0 and 1 each holding 1 item, `ptr`=2; assert reset for 1 cycle.
  - Required: `valid_out`=0, `ptr`=0, `ready_in`=1.
  - Required: the next item goes to lane 0.
